// File: rtl/dphy_hs_lane_serializer.sv
// D-PHY HS transmit model: sequences NUM_LANES data lanes through LP-11 -> LP-01 -> LP-00 ->
// HS-zero -> sync -> LSB-first payload -> trail -> LP-11, one HS bit per clk_i cycle.
module dphy_hs_lane_serializer #(
    parameter int          NUM_LANES = 4,
    parameter int          LPX_CYC   = 4,
    parameter int          PREP_CYC  = 4,
    parameter int          ZERO_CYC  = 8,
    parameter int          TRAIL_CYC = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hB8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   tx_req_i,
    input  logic [8*NUM_LANES-1:0] tx_data_i,
    input  logic                   tx_valid_i,
    input  logic                   tx_last_i,
    output logic                   tx_ready_o,
    output logic [NUM_LANES-1:0]   do_p_o,
    output logic [NUM_LANES-1:0]   do_n_o,
    output logic                   hs_active_o,
    output logic                   busy_o,
    output logic                   underrun_o
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = max_of(max_of(max_of(LPX_CYC, PREP_CYC), max_of(ZERO_CYC, TRAIL_CYC)), 8);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [2:0] ST_STOP  = 3'd0;
    localparam logic [2:0] ST_LPX   = 3'd1;
    localparam logic [2:0] ST_PREP  = 3'd2;
    localparam logic [2:0] ST_ZERO  = 3'd3;
    localparam logic [2:0] ST_SYNC  = 3'd4;
    localparam logic [2:0] ST_DATA  = 3'd5;
    localparam logic [2:0] ST_TRAIL = 3'd6;
    localparam logic [2:0] ST_EXIT  = 3'd7;

    logic [2:0]             state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [8*NUM_LANES-1:0] data_q;
    logic                   last_q;
    logic [NUM_LANES-1:0]   last_bits;
    logic [NUM_LANES-1:0]   hs_bits;
    logic [2:0]             bit_idx;
    logic                   term;
    logic                   accept;

    // Counter runs down to zero; in SYNC/DATA it doubles as the bit index.
    assign term    = (cnt == '0);
    assign bit_idx = 3'd7 - cnt[2:0];

    // Ready depends on state alone so the packet builder never sees a combinational loop.
    assign tx_ready_o  = term && ((state == ST_SYNC) || ((state == ST_DATA) && !last_q));
    assign accept      = tx_ready_o && tx_valid_i;
    assign underrun_o  = tx_ready_o && !tx_valid_i;
    assign busy_o      = (state != ST_STOP);
    assign hs_active_o = (state == ST_ZERO) || (state == ST_SYNC) ||
                         (state == ST_DATA) || (state == ST_TRAIL);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_nxt = state;
        cnt_nxt   = term ? cnt : cnt - CNT_W'(1);
        case (state)
            ST_STOP: begin
                if (tx_req_i) begin
                    state_nxt = ST_LPX;
                    cnt_nxt   = CNT_W'(LPX_CYC - 1);
                end
            end
            ST_LPX: if (term) begin
                state_nxt = ST_PREP;
                cnt_nxt   = CNT_W'(PREP_CYC - 1);
            end
            ST_PREP: if (term) begin
                state_nxt = ST_ZERO;
                cnt_nxt   = CNT_W'(ZERO_CYC - 1);
            end
            ST_ZERO: if (term) begin
                state_nxt = ST_SYNC;
                cnt_nxt   = CNT_W'(7);
            end
            ST_SYNC, ST_DATA: if (term) begin
                if (accept) begin
                    state_nxt = ST_DATA;
                    cnt_nxt   = CNT_W'(7);
                end else begin
                    // Either the last beat has finished or the builder failed to supply one.
                    state_nxt = ST_TRAIL;
                    cnt_nxt   = CNT_W'(TRAIL_CYC - 1);
                end
            end
            ST_TRAIL: if (term) begin
                state_nxt = ST_EXIT;
                cnt_nxt   = CNT_W'(LPX_CYC - 1);
            end
            ST_EXIT: if (term) begin
                state_nxt = ST_STOP;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = ST_STOP;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        hs_bits = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            logic [7:0] lane_byte;
            lane_byte = data_q[8*k +: 8];
            if (state == ST_SYNC)
                hs_bits[k] = SYNC_BYTE[bit_idx];
            else if (state == ST_DATA)
                hs_bits[k] = lane_byte[bit_idx];
        end
    end

    always_comb begin
        do_p_o = '1;
        do_n_o = '1;
        case (state)
            ST_LPX, ST_ZERO: do_p_o = '0;
            ST_PREP: begin
                do_p_o = '0;
                do_n_o = '0;
            end
            ST_SYNC, ST_DATA: begin
                do_p_o = hs_bits;
                do_n_o = ~hs_bits;
            end
            ST_TRAIL: begin
                do_p_o = ~last_bits;
                do_n_o = last_bits;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state     <= ST_STOP;
            cnt       <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            last_bits <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                data_q <= tx_data_i;
                last_q <= tx_last_i;
            end
            if ((state == ST_SYNC) || (state == ST_DATA))
                last_bits <= hs_bits;
        end
    end

endmodule

// File: tb/tb_dphy_hs_lane_serializer.sv
// Directed bench: a 4-lane and a 1-lane serializer run in lockstep against a cycle timeline model.
module tb_dphy_hs_lane_serializer;

    localparam logic [7:0] SYNC = 8'hB8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        tx_req = 1'b0;
    logic        tx_valid = 1'b0;
    logic        tx_last = 1'b0;
    logic [31:0] tx_data = '0;

    logic [3:0]  p4, n4;
    logic        rdy4, hs4, busy4, und4;
    logic [0:0]  p1, n1;
    logic        rdy1, hs1, busy1, und1;

    int n_tests = 0;
    int n_fail  = 0;

    // Scenario description consumed by the stimulus loop and the model.
    int          nb;
    int          under_cyc;
    bit          hold;
    logic [31:0] bd [3];

    always #5 clk = ~clk;

    dphy_hs_lane_serializer #(.NUM_LANES(4)) dut4 (
        .clk_i(clk), .reset_n_i(reset_n), .tx_req_i(tx_req), .tx_data_i(tx_data),
        .tx_valid_i(tx_valid), .tx_last_i(tx_last), .tx_ready_o(rdy4),
        .do_p_o(p4), .do_n_o(n4), .hs_active_o(hs4), .busy_o(busy4), .underrun_o(und4)
    );

    dphy_hs_lane_serializer #(.NUM_LANES(1)) dut1 (
        .clk_i(clk), .reset_n_i(reset_n), .tx_req_i(tx_req), .tx_data_i(tx_data[7:0]),
        .tx_valid_i(tx_valid), .tx_last_i(tx_last), .tx_ready_o(rdy1),
        .do_p_o(p1), .do_n_o(n1), .hs_active_o(hs1), .busy_o(busy1), .underrun_o(und1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Expected lane levels and flags for cycle cyc of the current scenario (req at cycle 0).
    task automatic model(input int cyc, output logic [3:0] ep, output logic [3:0] en,
                         output logic er, output logic eu, output logic eh, output logic eb);
        int         de, rl;
        logic [3:0] lb;
        logic [7:0] sb;
        sb = SYNC;
        de = 24 + 8 * nb;
        rl = (under_cyc < 0) ? de - 8 : de;
        lb = 4'hF;
        if (nb > 0) lb = {bd[nb-1][31], bd[nb-1][23], bd[nb-1][15], bd[nb-1][7]};
        ep = 4'hF; en = 4'hF; eh = 1'b0; eb = 1'b1;
        if (cyc == 0) eb = 1'b0;
        else if (cyc <= 4) ep = 4'h0;
        else if (cyc <= 8) begin ep = 4'h0; en = 4'h0; end
        else if (cyc <= 16) begin ep = 4'h0; eh = 1'b1; end
        else if (cyc <= 24) begin ep = {4{sb[cyc-17]}}; en = ~ep; eh = 1'b1; end
        else if (cyc <= de) begin
            for (int k = 0; k < 4; k++) ep[k] = bd[(cyc-25)/8][8*k + (cyc-25)%8];
            en = ~ep; eh = 1'b1;
        end
        else if (cyc <= de + 8) begin ep = ~lb; en = lb; eh = 1'b1; end
        else if (cyc <= de + 12) ;
        else if (hold && cyc > de + 13) ep = 4'h0;
        else eb = 1'b0;
        er = (cyc >= 24) && (cyc <= rl) && ((cyc - 24) % 8 == 0);
        eu = (cyc == under_cyc);
    endtask

    task automatic run(input int max_cyc, input string name);
        logic [3:0] ep, en;
        logic       er, eu, eh, eb;
        for (int cyc = 0; cyc <= max_cyc; cyc++) begin
            int j;
            j = (cyc <= 24) ? 0 : (cyc - 17) / 8;
            if (j > 2) j = 2;
            tx_req   = (cyc == 0) || hold;
            tx_valid = (cyc != under_cyc);
            tx_data  = bd[j];
            tx_last  = (under_cyc < 0) && (j == nb - 1);
            #1;
            model(cyc, ep, en, er, eu, eh, eb);
            check($sformatf("%s c%0d p4", name, cyc), p4, ep);
            check($sformatf("%s c%0d n4", name, cyc), n4, en);
            check($sformatf("%s c%0d rdy4", name, cyc), rdy4, er);
            check($sformatf("%s c%0d und4", name, cyc), und4, eu);
            check($sformatf("%s c%0d hs4", name, cyc), hs4, eh);
            check($sformatf("%s c%0d busy4", name, cyc), busy4, eb);
            check($sformatf("%s c%0d p1", name, cyc), p1, ep[0]);
            check($sformatf("%s c%0d n1", name, cyc), n1, en[0]);
            check($sformatf("%s c%0d rdy1", name, cyc), rdy1, er);
            check($sformatf("%s c%0d und1", name, cyc), und1, eu);
            check($sformatf("%s c%0d hs1", name, cyc), hs1, eh);
            check($sformatf("%s c%0d busy1", name, cyc), busy1, eb);
            @(posedge clk);
            #1;
        end
        tx_req = 1'b0; tx_valid = 1'b0; tx_last = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check({name, " p4"}, p4, 32'hF);
        check({name, " n4"}, n4, 32'hF);
        check({name, " busy4"}, busy4, 0);
        check({name, " hs4"}, hs4, 0);
        check({name, " rdy4"}, rdy4, 0);
        check({name, " und4"}, und4, 0);
        check({name, " p1"}, p1, 1);
        check({name, " busy1"}, busy1, 0);
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must react before any edge.
    task automatic reset_pulse(input string name);
        #2 reset_n = 1'b0;
        #1 check_idle({name, " async"});
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1 check_idle({name, " after"});
    endtask

    initial begin
        bd[0] = '0; bd[1] = '0; bd[2] = '0;
        nb = 0; under_cyc = -1; hold = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_idle("reset");
        #19 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single last beat, requested in the first cycle after reset release.
        nb = 1; under_cyc = -1; hold = 1'b0;
        bd[0] = 32'h04030201; bd[1] = 32'h0; bd[2] = 32'h0;
        run(50, "one");

        // Three back-to-back beats, valid held high throughout.
        nb = 3; under_cyc = -1;
        bd[0] = 32'hA5C3F00F; bd[1] = 32'h5A3C0FF0; bd[2] = 32'h8180FF01;
        run(63, "three");

        // Valid dropped at the second ready cycle.
        nb = 1; under_cyc = 32;
        bd[0] = 32'h80FF7F01; bd[1] = 32'hDEADBEEF; bd[2] = 32'h0;
        run(50, "und32");

        // Valid low at the sync ready cycle: zero-payload burst.
        nb = 0; under_cyc = 24;
        run(40, "und24");

        // Request held high: restart only after the four exit cycles.
        nb = 1; under_cyc = -1; hold = 1'b1;
        bd[0] = 32'h11223344;
        run(46, "hold");
        hold = 1'b0;
        reset_pulse("rst_lpx");

        // Reset asserted in the middle of a payload beat.
        nb = 3; under_cyc = -1;
        bd[0] = 32'hFFFFFFFF; bd[1] = 32'hFFFFFFFF; bd[2] = 32'hFFFFFFFF;
        run(27, "pre_rst");
        reset_pulse("rst_data");
        #1 check_idle("rst_data idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
